// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter stage of the MIPS datapath. It sits directly downstream of
// the shifter and receives the word-aligned branch offset (sext(imm16) << 2).
// The stage computes PC+4, the branch target and the jump target, and it
// registers the next fetch PC. After every taken redirect it raises a flush
// pulse to the fetch/decode boundary.
//
// Parameters
//   RESET_PC      PC loaded on reset (word aligned)
//   FLUSH_CYCLES  number of cycles flush_o stays high after a redirect (1..7)
//
// Ports
//   clk            in   1   system clock, all state updates on posedge
//   rst            in   1   synchronous, active-high reset
//   stall_i        in   1   hold PC (hazard unit)
//   branch_i       in   1   branch taken
//   br_offset_i    in   32  shifted branch offset from the shifter
//   jump_i         in   1   J/JAL taken
//   jump_addr_i    in   26  instr_index field of a J-type instruction
//   pc_o           out  32  current fetch address (registered)
//   pc_plus4_o     out  32  pc_o + 4 (combinational)
//   valid_o        out  1   pc_o is a valid fetch address (registered)
//   flush_o        out  1   squash the wrong-path instruction in IF/ID (registered)
//   redirect_cnt_o out  16  saturating count of accepted redirects
//                           (present only when PC_PERF_CNT_EN is defined)
//
// Configuration macro: PC_PERF_CNT_EN adds the redirect performance counter.
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] br_offset_i,
    input  logic        jump_i,
    input  logic [25:0] jump_addr_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
`ifdef PC_PERF_CNT_EN
    output logic        flush_o,
    output logic [15:0] redirect_cnt_o
`else
    output logic        flush_o
`endif
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StFlush
    } state_e;

    // The counter holds the number of flush cycles still to go after the
    // current one, so entry loads FLUSH_CYCLES-1 and exit happens at zero.
    localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

    // Low bits are cleared so a misconfigured RESET_PC still fetches aligned.
    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    state_e      r_state;
    logic [31:0] r_pc;
    logic        r_valid;
    logic        r_flush;
    logic [2:0]  r_flush_cnt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic        w_redirect;
    logic [31:0] w_redirect_tgt;

    // -----------------------------------------------------------------------
    // Target arithmetic (all modulo 2^32)
    // -----------------------------------------------------------------------
    assign w_pc_plus4 = r_pc + 32'd4;

    // The offset should already be word aligned; the mask guarantees it.
    assign w_br_tgt = (w_pc_plus4 + br_offset_i) & 32'hFFFF_FFFC;

    // The region bits come from PC+4, not PC, matching MIPS J semantics.
    assign w_j_tgt = {w_pc_plus4[31:28], jump_addr_i, 2'b00};

    assign w_redirect = jump_i | branch_i;

    // Jump has priority over branch when both are asserted.
    always_comb begin
        w_redirect_tgt = w_br_tgt;
        if (jump_i) begin
            w_redirect_tgt = w_j_tgt;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered PC, valid and flush
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StBoot;
            r_pc        <= ResetPcAligned;
            r_valid     <= 1'b0;
            r_flush     <= 1'b0;
            r_flush_cnt <= 3'd0;
        end else begin
            unique case (r_state)
                // One dead cycle after reset; inputs are ignored here.
                StBoot: begin
                    r_state <= StRun;
                    r_valid <= 1'b1;
                end

                // A redirect overrides a stall: the stalled instruction is on
                // the wrong path anyway.
                StRun: begin
                    if (w_redirect) begin
                        r_pc        <= w_redirect_tgt;
                        r_state     <= StFlush;
                        r_flush     <= 1'b1;
                        r_flush_cnt <= FlushLoad;
                    end else if (!stall_i) begin
                        r_pc <= w_pc_plus4;
                    end
                end

                // Redirect requests here come from squashed instructions and
                // are dropped. A stall freezes the PC but not the flush count.
                StFlush: begin
                    if (!stall_i) begin
                        r_pc <= w_pc_plus4;
                    end
                    if (r_flush_cnt == 3'd0) begin
                        r_state <= StRun;
                        r_flush <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end

                default: begin
                    r_state     <= StBoot;
                    r_valid     <= 1'b0;
                    r_flush     <= 1'b0;
                    r_flush_cnt <= 3'd0;
                end
            endcase
        end
    end

    assign pc_o       = r_pc;
    assign pc_plus4_o = w_pc_plus4;
    assign valid_o    = r_valid;
    assign flush_o    = r_flush;

`ifdef PC_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Saturating count of redirects actually taken (only those seen in RUN)
    // -----------------------------------------------------------------------
    logic [15:0] r_redirect_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_cnt <= 16'd0;
        end else if ((r_state == StRun) && w_redirect && (r_redirect_cnt != 16'hFFFF)) begin
            r_redirect_cnt <= r_redirect_cnt + 16'd1;
        end
    end

    assign redirect_cnt_o = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with FLUSH_CYCLES = 1
    logic        rst, stall, branch, jump;
    logic [31:0] off;
    logic [25:0] jaddr;
    logic [31:0] pc, pc4;
    logic        valid, flush;

    // Instance with FLUSH_CYCLES = 3
    logic        rst3, stall3, branch3, jump3;
    logic [31:0] off3;
    logic [25:0] jaddr3;
    logic [31:0] pc3, pc43;
    logic        valid3, flush3;

`ifdef PC_PERF_CNT_EN
    logic [15:0] cnt1, cnt3;
`endif

    int n_vec = 0;
    int n_err = 0;

    pc_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .FLUSH_CYCLES(1)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .branch_i      (branch),
        .br_offset_i   (off),
        .jump_i        (jump),
        .jump_addr_i   (jaddr),
        .pc_o          (pc),
        .pc_plus4_o    (pc4),
        .valid_o       (valid),
`ifdef PC_PERF_CNT_EN
        .flush_o       (flush),
        .redirect_cnt_o(cnt1)
`else
        .flush_o       (flush)
`endif
    );

    pc_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .FLUSH_CYCLES(3)
    ) u_dut3 (
        .clk           (clk),
        .rst           (rst3),
        .stall_i       (stall3),
        .branch_i      (branch3),
        .br_offset_i   (off3),
        .jump_i        (jump3),
        .jump_addr_i   (jaddr3),
        .pc_o          (pc3),
        .pc_plus4_o    (pc43),
        .valid_o       (valid3),
`ifdef PC_PERF_CNT_EN
        .flush_o       (flush3),
        .redirect_cnt_o(cnt3)
`else
        .flush_o       (flush3)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect1(input string tag, input logic [31:0] e_pc, input logic e_valid,
                           input logic e_flush);
        check_val({tag, ".pc"}, pc, e_pc);
        check_val({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
        check_val({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
    endtask

    task automatic expect3(input string tag, input logic [31:0] e_pc, input logic e_valid,
                           input logic e_flush);
        check_val({tag, ".pc"}, pc3, e_pc);
        check_val({tag, ".valid"}, {31'd0, valid3}, {31'd0, e_valid});
        check_val({tag, ".flush"}, {31'd0, flush3}, {31'd0, e_flush});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch = 1'b0; jump = 1'b0; off = '0; jaddr = '0;
        rst3 = 1'b1; stall3 = 1'b0; branch3 = 1'b0; jump3 = 1'b0; off3 = '0; jaddr3 = '0;

        // T1: reset, boot, sequential fetch
        tick();
        expect1("t1_boot", 32'h0, 1'b0, 1'b0);
        check_val("t1_boot.pc4", pc4, 32'h4);
        rst = 1'b0;
        tick(); expect1("t1_run0", 32'h0, 1'b1, 1'b0);
        tick(); expect1("t1_run4", 32'h4, 1'b1, 1'b0);
        tick(); expect1("t1_run8", 32'h8, 1'b1, 1'b0);
        repeat (14) tick();
        expect1("t1_run40", 32'h40, 1'b1, 1'b0);

        // T2: backward branch
        branch = 1'b1; off = 32'hFFFF_FFE0;
        tick(); branch = 1'b0;
        expect1("t2_tgt", 32'h24, 1'b1, 1'b1);
        tick();
        expect1("t2_after", 32'h28, 1'b1, 1'b0);
        check_val("t2_pc4", pc4, 32'h2C);

        // Move to 0x1000_0000 via a branch to 0x0FFF_FFFC plus one flush cycle
        branch = 1'b1; off = 32'h0FFF_FFD0;
        tick(); branch = 1'b0;
        expect1("t3_pre", 32'h0FFF_FFFC, 1'b1, 1'b1);
        tick();
        expect1("t3_base", 32'h1000_0000, 1'b1, 1'b0);

        // T3: jump beats branch; branch during FLUSH is ignored
        jump = 1'b1; branch = 1'b1; jaddr = 26'h10; off = 32'h100;
        tick(); jump = 1'b0;
        expect1("t3_jmp", 32'h1000_0040, 1'b1, 1'b1);
        tick(); branch = 1'b0;
        expect1("t3_flush_br", 32'h1000_0044, 1'b1, 1'b0);

        // T4: branch to 0x80, stall three cycles, then stall+branch
        branch = 1'b1; off = 32'hF000_0038;
        tick(); branch = 1'b0; stall = 1'b1;
        expect1("t4_tgt", 32'h80, 1'b1, 1'b1);
        tick(); expect1("t4_stall1", 32'h80, 1'b1, 1'b0);
        tick(); expect1("t4_stall2", 32'h80, 1'b1, 1'b0);
        tick(); expect1("t4_stall3", 32'h80, 1'b1, 1'b0);
        branch = 1'b1; off = 32'h10;
        tick(); branch = 1'b0; stall = 1'b0;
        expect1("t4_stall_br", 32'h94, 1'b1, 1'b1);
        tick(); expect1("t4_after", 32'h98, 1'b1, 1'b0);

        // Misaligned offset: target low bits are cleared (0x9C+0x13=0xAF -> 0xAC)
        branch = 1'b1; off = 32'h13;
        tick(); branch = 1'b0;
        expect1("align_tgt", 32'hAC, 1'b1, 1'b1);
        tick(); expect1("align_after", 32'hB0, 1'b1, 1'b0);

        // T5a: wrap-around at the top of the address space
        branch = 1'b1; off = 32'hFFFF_FF48;
        tick(); branch = 1'b0;
        expect1("t5_top", 32'hFFFF_FFFC, 1'b1, 1'b1);
        check_val("t5_top.pc4", pc4, 32'h0);
        tick(); expect1("t5_wrap", 32'h0, 1'b1, 1'b0);

        // Jump region bits taken from PC+4 (0x0FFF_FFFC + 4 -> region 1)
        branch = 1'b1; off = 32'h0FFF_FFF4;
        tick(); branch = 1'b0;
        expect1("jreg_pre", 32'h0FFF_FFF8, 1'b1, 1'b1);
        tick(); expect1("jreg_pc", 32'h0FFF_FFFC, 1'b1, 1'b0);
        jump = 1'b1; jaddr = 26'h3;
        tick(); jump = 1'b0;
        expect1("jreg_tgt", 32'h1000_000C, 1'b1, 1'b1);
        tick(); expect1("jreg_after", 32'h1000_0010, 1'b1, 1'b0);

        // Jump wins over stall
        stall = 1'b1; jump = 1'b1; jaddr = 26'h20;
        tick(); stall = 1'b0; jump = 1'b0;
        expect1("jstall_tgt", 32'h1000_0080, 1'b1, 1'b1);
        tick(); expect1("jstall_after", 32'h1000_0084, 1'b1, 1'b0);

        // T5b: FLUSH_CYCLES=3 length, then reset in the 2nd flush cycle
        rst3 = 1'b0;
        tick(); expect3("t5b_run0", 32'h0, 1'b1, 1'b0);
        branch3 = 1'b1; off3 = 32'h20;
        tick(); branch3 = 1'b0;
        expect3("t5b_f1", 32'h24, 1'b1, 1'b1);
        tick(); expect3("t5b_f2", 32'h28, 1'b1, 1'b1);
        tick(); expect3("t5b_f3", 32'h2C, 1'b1, 1'b1);
        tick(); expect3("t5b_end", 32'h30, 1'b1, 1'b0);
        branch3 = 1'b1; off3 = 32'h0;
        tick(); branch3 = 1'b0;
        expect3("t5b_g1", 32'h34, 1'b1, 1'b1);
        tick(); expect3("t5b_g2", 32'h38, 1'b1, 1'b1);
        rst3 = 1'b1;
        tick(); rst3 = 1'b0;
        expect3("t5b_rst", 32'h0, 1'b0, 1'b0);
        tick(); expect3("t5b_reboot", 32'h0, 1'b1, 1'b0);

`ifdef PC_PERF_CNT_EN
        // T6: redirect counter and saturation
        check_val("t6_cnt0", {16'd0, cnt3}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            branch3 = 1'b1; off3 = 32'h0;
            tick(); branch3 = 1'b0;
            repeat (3) tick();
        end
        check_val("t6_cnt3", {16'd0, cnt3}, 32'd3);
        force u_dut3.r_redirect_cnt = 16'hFFFF;
        #1;
        release u_dut3.r_redirect_cnt;
        branch3 = 1'b1;
        tick(); branch3 = 1'b0;
        check_val("t6_sat", {16'd0, cnt3}, 32'h0000_FFFF);
        repeat (3) tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
